pwm_demodulator: RTL and testbench

Recovers sample amplitudes from a PWM waveform of the kind produced by the team's modulator_ip. Each PWM period is measured as high time and total period in `clk` cycles. The block then computes `ampl = floor(high * 2^width_p / period)` with a bit-serial divider and presents each recovered sample with a one-cycle valid strobe. It sits at the receive end of a board-to-board or loopback PWM link, behind the same clock wrapper as the modulator.

---
 rtl/pwm_demodulator.sv | 204 ++++++++++++++++++++
 tb/tb_pwm_demodulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demodulator.sv
// Recovers PWM sample amplitudes: measures high time and period per PWM cycle,
// then computes floor(high * 2^width_p / period) with a restoring bit-serial divider.
module pwm_demodulator #(
    parameter int unsigned width_p     = 12,
    parameter int unsigned cnt_width_p = 32,
    parameter int unsigned timeout_p   = 2**24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pwm_in,
    output logic [width_p-1:0]     ampl_out,
    output logic                   ampl_valid,
    output logic [cnt_width_p-1:0] high_cnt_out,
    output logic [cnt_width_p-1:0] period_cnt_out,
    output logic                   signal_lost,
    output logic                   drop_pulse
);

    localparam int unsigned StepW = $clog2(width_p + 1);
    localparam logic [StepW-1:0]       LastStep    = StepW'(width_p - 1);
    localparam logic [cnt_width_p-1:0] CntOne      = cnt_width_p'(1);
    localparam logic [cnt_width_p-1:0] CntMax      = '1;
    localparam logic [cnt_width_p-1:0] TimeoutLast = cnt_width_p'(timeout_p - 1);

    typedef enum logic {IDLE, MEASURE} meas_state_e;
    typedef enum logic {DIV_IDLE, DIV_RUN} div_state_e;

    meas_state_e meas_state_q, meas_state_d;
    div_state_e  div_state_q, div_state_d;

    logic [2:0]             sync_q;
    logic [cnt_width_p-1:0] idle_cnt_q;
    logic [cnt_width_p-1:0] period_cnt_q;
    logic [cnt_width_p-1:0] high_cnt_q;
    logic [cnt_width_p:0]   rem_q;
    logic [cnt_width_p-1:0] divisor_q;
    logic [cnt_width_p-1:0] hold_high_q;
    logic [width_p-1:0]     quot_q;
    logic [StepW-1:0]       step_q;
    logic [width_p-1:0]     ampl_q;
    logic [cnt_width_p-1:0] high_out_q;
    logic [cnt_width_p-1:0] period_out_q;
    logic                   ampl_valid_q;
    logic                   lost_q;
    logic                   drop_q;

    logic                   rise;
    logic                   fall;
    logic                   timeout;
    logic                   period_complete;
    logic                   accept;
    logic                   drop;
    logic                   div_last;
    logic [cnt_width_p:0]   rem_shift;
    logic [cnt_width_p:0]   divisor_ext;
    logic                   q_bit;
    logic [cnt_width_p:0]   rem_next;
    logic [width_p-1:0]     quot_next;

    // sync_q[1] is the synchronized input; sync_q[2] is its one-cycle-old copy
    assign rise    = sync_q[1] & ~sync_q[2];
    assign fall    = ~sync_q[1] & sync_q[2];
    assign timeout = ~(rise | fall) && (idle_cnt_q == TimeoutLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            idle_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pwm_in};
            if (rise || fall || timeout) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_state_q <= IDLE;
            div_state_q  <= DIV_IDLE;
        end else begin
            meas_state_q <= meas_state_d;
            div_state_q  <= div_state_d;
        end
    end

    // The opening rise leaves IDLE; every rise seen in MEASURE closes a period
    always_comb begin
        meas_state_d    = meas_state_q;
        period_complete = 1'b0;
        case (meas_state_q)
            IDLE: begin
                if (rise) begin
                    meas_state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    meas_state_d = IDLE;
                end else if (rise) begin
                    period_complete = 1'b1;
                end
            end
            default: meas_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
        end else if (rise) begin
            period_cnt_q <= CntOne;
            high_cnt_q   <= CntOne;
        end else if (meas_state_q == MEASURE) begin
            if (period_cnt_q != CntMax) begin
                period_cnt_q <= period_cnt_q + CntOne;
            end
            if (sync_q[1] && (high_cnt_q != CntMax)) begin
                high_cnt_q <= high_cnt_q + CntOne;
            end
        end
    end

    assign accept = period_complete && (div_state_q == DIV_IDLE) && (period_cnt_q != CntMax);
    assign drop   = period_complete && !accept;

    always_comb begin
        div_state_d = div_state_q;
        div_last    = 1'b0;
        case (div_state_q)
            DIV_IDLE: begin
                if (accept) begin
                    div_state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (timeout) begin
                    div_state_d = DIV_IDLE;
                end else if (step_q == LastStep) begin
                    div_state_d = DIV_IDLE;
                    div_last    = 1'b1;
                end
            end
            default: div_state_d = DIV_IDLE;
        endcase
    end

    // high < period keeps rem below the divisor, so the shift never loses a set bit
    assign rem_shift   = rem_q << 1;
    assign divisor_ext = {1'b0, divisor_q};
    assign q_bit       = (rem_shift >= divisor_ext);
    assign rem_next    = q_bit ? (rem_shift - divisor_ext) : rem_shift;
    assign quot_next   = (quot_q << 1) | width_p'(q_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q        <= '0;
            divisor_q    <= '0;
            hold_high_q  <= '0;
            quot_q       <= '0;
            step_q       <= '0;
            ampl_q       <= '0;
            high_out_q   <= '0;
            period_out_q <= '0;
            ampl_valid_q <= 1'b0;
            lost_q       <= 1'b1;
            drop_q       <= 1'b0;
        end else begin
            ampl_valid_q <= 1'b0;
            drop_q       <= drop;
            if (accept) begin
                rem_q       <= {1'b0, high_cnt_q};
                divisor_q   <= period_cnt_q;
                hold_high_q <= high_cnt_q;
                quot_q      <= '0;
                step_q      <= '0;
            end else if (div_state_q == DIV_RUN) begin
                rem_q  <= rem_next;
                quot_q <= quot_next;
                step_q <= step_q + 1'b1;
            end
            if (div_last) begin
                ampl_q       <= quot_next;
                high_out_q   <= hold_high_q;
                period_out_q <= divisor_q;
                ampl_valid_q <= 1'b1;
                lost_q       <= 1'b0;
            end else if (timeout) begin
                lost_q <= 1'b1;
            end
        end
    end

    assign ampl_out       = ampl_q;
    assign ampl_valid     = ampl_valid_q;
    assign high_cnt_out   = high_out_q;
    assign period_cnt_out = period_out_q;
    assign signal_lost    = lost_q;
    assign drop_pulse     = drop_q;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Bench for pwm_demodulator: an edge-timestamp model predicts every strobe, drop
// and signal-loss event; literal checks pin the expected amplitudes.
module tb_pwm_demodulator;

    localparam int WIDTH   = 12;
    localparam int CNTW    = 32;
    localparam int TIMEOUT = 4500;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pwm_in = 1'b0;
    logic [WIDTH-1:0] ampl_out;
    logic            ampl_valid;
    logic [CNTW-1:0] high_cnt_out;
    logic [CNTW-1:0] period_cnt_out;
    logic            signal_lost;
    logic            drop_pulse;

    pwm_demodulator #(
        .width_p    (WIDTH),
        .cnt_width_p(CNTW),
        .timeout_p  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pwm_in        (pwm_in),
        .ampl_out      (ampl_out),
        .ampl_valid    (ampl_valid),
        .high_cnt_out  (high_cnt_out),
        .period_cnt_out(period_cnt_out),
        .signal_lost   (signal_lost),
        .drop_pulse    (drop_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ampl;
        int high;
        int period;
    } sample_t;

    sample_t expQ[$];
    int      dropQ[$];
    int      total = 0;
    int      bad = 0;
    bit      checkEn = 1'b0;
    bit      opened = 1'b0;
    int      riseN = 0;
    int      fallN = 0;
    int      lastEdgeN = 0;
    int      lastAccN = -100000;
    int      mAmpl = 0;
    int      mHigh = 0;
    int      mPeriod = 0;
    bit      mLost = 1'b1;
    int      validSeen = 0;
    int      dropSeen = 0;

    // Edges are driven on falling clk edges, so detection lags the drive by a
    // fixed 2 cycles; a strobe lands width+1 cycles after the detected rise.
    task automatic modelEdge(input logic lvl);
        sample_t s;
        int n;
        n = cyc;
        if (n - lastEdgeN > TIMEOUT) begin
            opened   = 1'b0;
            lastAccN = -100000;
        end
        lastEdgeN = n;
        if (lvl) begin
            if (opened) begin
                if (n - lastAccN <= WIDTH) begin
                    dropQ.push_back(n + 3);
                end else begin
                    s.cyc    = n + WIDTH + 3;
                    s.high   = fallN - riseN;
                    s.period = n - riseN;
                    s.ampl   = int'((longint'(s.high) << WIDTH) / longint'(s.period));
                    expQ.push_back(s);
                    lastAccN = n;
                end
            end
            opened = 1'b1;
            riseN  = n;
        end else begin
            fallN = n;
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        dropQ.delete();
        opened    = 1'b0;
        lastAccN  = -100000;
        lastEdgeN = cyc;
        mAmpl     = 0;
        mHigh     = 0;
        mPeriod   = 0;
        mLost     = 1'b1;
    endtask

    task automatic driveLevel(input logic lvl, input int cycles);
        if (pwm_in !== lvl) begin
            pwm_in = lvl;
            modelEdge(lvl);
        end
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyStimulus(input int high, input int period, input int n);
        for (int i = 0; i < n; i++) begin
            driveLevel(1'b1, high);
            driveLevel(1'b0, period - high);
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Compares every output against the model on each falling clk edge
    task automatic runCompare();
        sample_t s;
        logic    validExp;
        logic    dropExp;
        forever begin
            @(negedge clk);
            if (checkEn && !rst) begin
                validExp = 1'b0;
                dropExp  = 1'b0;
                if (dropQ.size() > 0 && dropQ[0] == cyc) begin
                    dropQ.delete(0);
                    dropExp = 1'b1;
                end
                if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                    s        = expQ.pop_front();
                    validExp = 1'b1;
                    mAmpl    = s.ampl;
                    mHigh    = s.high;
                    mPeriod  = s.period;
                    mLost    = 1'b0;
                end
                if (cyc - lastEdgeN >= TIMEOUT + 3) mLost = 1'b1;
                if (ampl_valid === 1'b1) validSeen++;
                if (drop_pulse === 1'b1) dropSeen++;
                total++;
                if (ampl_valid !== validExp || drop_pulse !== dropExp || signal_lost !== mLost ||
                    ampl_out !== WIDTH'(mAmpl) || high_cnt_out !== CNTW'(mHigh) ||
                    period_cnt_out !== CNTW'(mPeriod)) begin
                    bad++;
                    $display("[TB] FAIL cycle %0d outputs: got valid=%0b drop=%0b lost=%0b ampl=%0d high=%0d period=%0d, want valid=%0b drop=%0b lost=%0b ampl=%0d high=%0d period=%0d",
                             cyc, ampl_valid, drop_pulse, signal_lost, ampl_out, high_cnt_out, period_cnt_out,
                             validExp, dropExp, mLost, mAmpl, mHigh, mPeriod);
                end
            end
        end
    endtask

    initial begin
        int v0;
        int d0;
        fork
            runCompare();
        join_none

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("reset ampl_out", ampl_out, 0);
        checkOutput("reset ampl_valid", ampl_valid, 0);
        checkOutput("reset drop_pulse", drop_pulse, 0);
        checkOutput("reset signal_lost", signal_lost, 1);
        checkOutput("reset high_cnt_out", high_cnt_out, 0);
        checkOutput("reset period_cnt_out", period_cnt_out, 0);
        modelReset();
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        checkEn = 1'b1;
        modelReset();
        repeat (5) @(negedge clk);

        v0 = validSeen;
        applyStimulus(250, 1000, 3);
        checkOutput("nominal strobe count", validSeen - v0, 2);
        checkOutput("nominal ampl", ampl_out, 1024);
        checkOutput("nominal high", high_cnt_out, 250);
        checkOutput("nominal period", period_cnt_out, 1000);
        checkOutput("nominal lost", signal_lost, 0);

        applyStimulus(999, 1000, 2);
        checkOutput("high duty ampl", ampl_out, 4091);

        applyStimulus(1, 4096, 2);
        checkOutput("low duty ampl", ampl_out, 1);
        checkOutput("low duty period", period_cnt_out, 4096);

        v0 = validSeen;
        d0 = dropSeen;
        applyStimulus(5, 10, 10);
        checkOutput("short period drops", dropSeen - d0, 5);
        checkOutput("short period strobes", validSeen - v0, 5);
        checkOutput("short period ampl", ampl_out, 2048);

        applyStimulus(20, 50, 3);
        driveLevel(1'b1, 2 * TIMEOUT);
        checkOutput("timeout lost", signal_lost, 1);
        checkOutput("timeout ampl held", ampl_out, 1638);
        v0 = validSeen;
        driveLevel(1'b0, 25);
        applyStimulus(30, 60, 2);
        checkOutput("recovery strobes", validSeen - v0, 1);
        checkOutput("recovery lost", signal_lost, 0);
        checkOutput("recovery ampl", ampl_out, 2048);

        driveLevel(1'b1, 5);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid-divide reset ampl", ampl_out, 0);
        checkOutput("mid-divide reset lost", signal_lost, 1);
        checkOutput("mid-divide reset period", period_cnt_out, 0);
        pwm_in = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
        repeat (5) @(negedge clk);
        v0 = validSeen;
        applyStimulus(400, 800, 2);
        checkOutput("post-reset strobes", validSeen - v0, 1);
        checkOutput("post-reset ampl", ampl_out, 2048);
        checkOutput("post-reset high", high_cnt_out, 400);
        checkOutput("post-reset period", period_cnt_out, 800);

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
